// File: rtl/race_controller.sv
// Race controller for a two-racer typing game: countdown, then both racers
// burn down a BCD box count; first to reach 00 wins, simultaneous 00 is a tie.
module race_controller #(
  parameter logic [3:0] START_TENS = 4'd3,
  parameter logic [3:0] START_ONES = 4'd2,
  parameter logic [3:0] COUNTDOWN  = 4'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       sec_tick,
  input  logic       player_hit,
  input  logic       pc_hit,
  output logic [3:0] player_q1,
  output logic [3:0] player_q0,
  output logic [3:0] pc_q1,
  output logic [3:0] pc_q0,
  output logic [3:0] count_digit,
  output logic       racing,
  output logic       done,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {IDLE, COUNT, RACE, DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] player_q, player_d;   // {tens, ones} BCD
  logic [7:0] pc_q, pc_d;
  logic [3:0] count_q, count_d;
  logic       racing_q, racing_d;
  logic       done_q, done_d;
  logic [1:0] winner_q, winner_d;
  logic [7:0] player_next, pc_next;

  // One BCD decrement with borrow; saturates at 00 so a score never wraps.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v == 8'h00)
      return 8'h00;
    else if (v[3:0] != 4'd0)
      return {v[7:4], v[3:0] - 4'd1};
    else
      return {v[7:4] - 4'd1, 4'd9};
  endfunction

  // Next-state and next-output computation; outputs derive from the next state
  // so every output is a flop.
  always_comb begin
    state_d     = state_q;
    player_d    = player_q;
    pc_d        = pc_q;
    count_d     = count_q;
    winner_d    = winner_q;
    player_next = player_q;
    pc_next     = pc_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = COUNT;
          player_d = {START_TENS, START_ONES};
          pc_d     = {START_TENS, START_ONES};
          count_d  = COUNTDOWN;
          winner_d = 2'b00;
        end
      end
      COUNT: begin
        if (sec_tick) begin
          if (count_q <= 4'd1) begin
            count_d = 4'd0;
            state_d = RACE;
          end else begin
            count_d = count_q - 4'd1;
          end
        end
      end
      RACE: begin
        if (player_hit) player_next = bcd_dec(player_q);
        if (pc_hit)     pc_next     = bcd_dec(pc_q);
        player_d = player_next;
        pc_d     = pc_next;
        if ((player_next == 8'h00) || (pc_next == 8'h00)) begin
          state_d  = DONE;
          winner_d = {pc_next == 8'h00, player_next == 8'h00};
        end
      end
      default: state_d = IDLE;
    endcase
    racing_d = (state_d == RACE);
    done_d   = (state_d == DONE);
  end

  // State and output registers with synchronous reset that aborts any race.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      player_q <= {START_TENS, START_ONES};
      pc_q     <= {START_TENS, START_ONES};
      count_q  <= COUNTDOWN;
      racing_q <= 1'b0;
      done_q   <= 1'b0;
      winner_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      player_q <= player_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      racing_q <= racing_d;
      done_q   <= done_d;
      winner_q <= winner_d;
    end
  end

  assign player_q1   = player_q[7:4];
  assign player_q0   = player_q[3:0];
  assign pc_q1       = pc_q[7:4];
  assign pc_q0       = pc_q[3:0];
  assign count_digit = count_q;
  assign racing      = racing_q;
  assign done        = done_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_race_controller.sv
// Scoreboard bench for race_controller: stimulus pushes the reference model's
// expected outputs, a monitor pops and compares one vector per clock.
module tb_race_controller;

  logic       clk = 1'b0;
  logic       reset, start, sec_tick, player_hit, pc_hit;
  logic [3:0] player_q1, player_q0, pc_q1, pc_q0, count_digit;
  logic       racing, done;
  logic [1:0] winner;

  int n_vec = 0;
  int n_err = 0;
  logic [23:0] exp_q[$];

  // Reference model: integer scores, state as a small number.
  // 0 idle, 1 countdown, 2 racing, 3 finished.
  int m_state, m_pl, m_pc, m_cd, m_win;

  always #5 clk = ~clk;

  race_controller dut (
    .clk(clk), .reset(reset), .start(start), .sec_tick(sec_tick),
    .player_hit(player_hit), .pc_hit(pc_hit),
    .player_q1(player_q1), .player_q0(player_q0),
    .pc_q1(pc_q1), .pc_q0(pc_q0),
    .count_digit(count_digit), .racing(racing), .done(done), .winner(winner)
  );

  task automatic model_step(input bit rst, st, tk, ph, pch);
    if (rst) begin
      m_state = 0; m_pl = 32; m_pc = 32; m_cd = 3; m_win = 0;
    end else if (m_state == 0 || m_state == 3) begin
      if (st) begin
        m_state = 1; m_pl = 32; m_pc = 32; m_cd = 3; m_win = 0;
      end
    end else if (m_state == 1) begin
      if (tk) begin
        m_cd = m_cd - 1;
        if (m_cd == 0) m_state = 2;
      end
    end else begin
      if (ph && m_pl > 0) m_pl = m_pl - 1;
      if (pch && m_pc > 0) m_pc = m_pc - 1;
      if (m_pl == 0 || m_pc == 0) begin
        m_state = 3;
        m_win = (m_pl == 0 ? 1 : 0) + (m_pc == 0 ? 2 : 0);
      end
    end
  endtask

  function automatic logic [23:0] model_outputs();
    return {4'(m_pl / 10), 4'(m_pl % 10), 4'(m_pc / 10), 4'(m_pc % 10),
            4'(m_cd), m_state == 2, m_state == 3, 2'(m_win)};
  endfunction

  // Drive one cycle of inputs and queue what the outputs must be after the edge.
  task automatic cycle(input bit rst, st, tk, ph, pch);
    @(negedge clk);
    reset = rst; start = st; sec_tick = tk; player_hit = ph; pc_hit = pch;
    model_step(rst, st, tk, ph, pch);
    exp_q.push_back(model_outputs());
  endtask

  task automatic run_countdown();
    for (int i = 0; i < 60 && m_state == 1; i++)
      cycle(0, 1'($urandom % 2), 1'(i % 3 == 2), 1'($urandom % 2), 1'($urandom % 2));
  endtask

  // Monitor: every clock, one expected vector is compared just after the edge.
  initial begin
    logic [23:0] e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {player_q1, player_q0, pc_q1, pc_q0, count_digit, racing, done, winner};
        n_vec++;
        if (a !== e)
          begin
            n_err++;
            $display("FAIL outputs vec %0d: got pl=%h%h pc=%h%h cd=%h rac=%b dn=%b win=%b, want pl=%h%h pc=%h%h cd=%h rac=%b dn=%b win=%b",
                     n_vec, a[23:20], a[19:16], a[15:12], a[11:8], a[7:4], a[3], a[2], a[1:0],
                     e[23:20], e[19:16], e[15:12], e[11:8], e[7:4], e[3], e[2], e[1:0]);
          end
        else
          $display("vec %0d ok: pl=%h%h pc=%h%h cd=%h rac=%b dn=%b win=%b",
                   n_vec, a[23:20], a[19:16], a[15:12], a[11:8], a[7:4], a[3], a[2], a[1:0]);
      end
    end
  end

  initial begin
    int k;
    reset = 1'b1; start = 1'b0; sec_tick = 1'b0; player_hit = 1'b0; pc_hit = 1'b0;
    m_state = 0; m_pl = 32; m_pc = 32; m_cd = 3; m_win = 0;

    // Reset, including reset winning over every simultaneous input.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 1, 1, 1);
    repeat (3) cycle(0, 0, 1, 1, 1);

    // Countdown: hits and start are ignored, three ticks reach the race.
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 1, 1);
      cycle(0, 1, 0, 1, 0);
      cycle(0, 0, 1, 1, 1);
    end

    // BCD borrow: 32 -> 31 -> 30 -> 29.
    repeat (3) cycle(0, 0, 0, 1, 0);

    // Player win with five PC hits interleaved, then hits in DONE do nothing.
    k = 0;
    for (int i = 0; i < 200 && m_state == 2; i++) begin
      if (k < 5 && i % 6 == 2) begin
        cycle(0, 0, 0, 0, 1);
        k++;
      end else begin
        cycle(0, 0, 0, 1, 0);
      end
    end
    repeat (3) cycle(0, 0, 1, 1, 1);

    // Restart from DONE, then tie from 01/01.
    cycle(0, 1, 0, 0, 0);
    run_countdown();
    for (int i = 0; i < 100 && m_state == 2 && (m_pl > 1 || m_pc > 1); i++)
      cycle(0, 0, 0, m_pl > 1, m_pc > 1);
    cycle(0, 0, 0, 1, 1);
    repeat (2) cycle(0, 0, 0, 1, 1);

    // Reset mid-race at player score 17, with an ignored start before it.
    cycle(0, 1, 0, 0, 0);
    run_countdown();
    for (int i = 0; i < 40 && m_state == 2 && m_pl > 17; i++)
      cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 1, 0, 0);
    cycle(1, 0, 0, 1, 1);
    repeat (2) cycle(0, 0, 1, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++)
      cycle(1'($urandom % 200 == 0), 1'($urandom % 25 == 0), 1'($urandom % 4 == 0),
            1'($urandom % 3 == 0), 1'($urandom % 3 == 0));

    @(negedge clk);
    reset = 1'b0; start = 1'b0; sec_tick = 1'b0; player_hit = 1'b0; pc_hit = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d vectors pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
